// File: rtl/core_pkg.sv
// Shared types and sizes for the memory stage: FSM state encoding and vector geometry.
package core_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   localparam int WORD_W = 32;
   localparam int VLANES = 4;
endpackage

// File: rtl/dmem_beat_ctrl.sv
// Data-memory beat sequencer: walks one (scalar) or LANES (vector) word beats over the
// req/ack bus, generating word-aligned addresses and the front-end stall.
//
//   state  | meaning
//   IDLE   | no transaction; a pending access starts one next cycle (stall already high)
//   ACCESS | bus request active for the current beat; advance on ack
//   DONE   | final beat acknowledged; MEM/WB captures the result on the closing edge
module dmem_beat_ctrl
   import core_pkg::*;
#(
   parameter int LANES = VLANES,
   parameter int BW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              access_i,
   input  logic              store_i,
   input  logic              vector_i,
   input  logic [WORD_W-1:0] base_addr_i,
   input  logic              dmem_ack_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [WORD_W-1:0] dmem_addr_o,
   output logic [BW-1:0]     beat_o,
   output logic              done_o,
   output logic              stall_o
);
   mem_state_t        state_q;
   logic [BW-1:0]     beat_q;
   logic [BW-1:0]     last_beat;
   logic              req_q;
   logic              we_q;
   logic [WORD_W-1:0] addr_q;

   assign last_beat = vector_i ? BW'(LANES - 1) : '0;

   // Bus outputs are registered, so they stay put across wait cycles by construction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (access_i) begin
                  state_q <= ACCESS;
                  beat_q  <= '0;
                  req_q   <= 1'b1;
                  we_q    <= store_i;
                  addr_q  <= {base_addr_i[WORD_W-1:2], 2'b00};
               end
            end
            ACCESS: begin
               if (dmem_ack_i) begin
                  if (beat_q == last_beat) begin
                     state_q <= DONE;
                     beat_q  <= '0;
                     req_q   <= 1'b0;
                     we_q    <= 1'b0;
                     addr_q  <= '0;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                     addr_q <= addr_q + WORD_W'(4);
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem_req_o  = req_q;
   assign dmem_we_o   = we_q;
   assign dmem_addr_o = addr_q;
   assign beat_o      = beat_q;
   assign done_o      = (state_q == DONE);
   assign stall_o     = ((state_q == IDLE) && access_i) || (state_q == ACCESS);
endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: scalar/vector loads and stores over a 32-bit req/ack bus,
// load-lane assembly, and the MEM/WB pipeline register.
module stage_memory
   import core_pkg::*;
#(
   parameter int XLEN  = WORD_W,
   parameter int LANES = VLANES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_clear,
   input  logic [31:0]           mem_instr,
   input  logic                  mem_reg_write,
   input  logic                  mem_mem_write,
   input  logic                  mem_mem_read,
   input  logic                  mem_vector_op,
   input  logic [1:0]            mem_result_src,
   input  logic [XLEN*LANES-1:0] mem_alu_result,
   input  logic [XLEN*LANES-1:0] mem_write_data,
   input  logic [31:0]           mem_pc_plus_4,
   input  logic [XLEN*LANES-1:0] mem_imm_ext,
   input  logic [4:0]            mem_rd,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [31:0]           dmem_addr,
   output logic [XLEN-1:0]       dmem_wdata,
   input  logic [XLEN-1:0]       dmem_rdata,
   input  logic                  dmem_ack,
   output logic                  mem_stall,
   output logic [31:0]           wb_instr,
   output logic                  wb_reg_write,
   output logic [1:0]            wb_result_src,
   output logic                  wb_vector_op,
   output logic [XLEN*LANES-1:0] wb_alu_result,
   output logic [XLEN*LANES-1:0] wb_read_data,
   output logic [31:0]           wb_pc_plus_4,
   output logic [XLEN*LANES-1:0] wb_imm_ext,
   output logic [4:0]            wb_rd
);
   localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;

   logic                       access;
   logic                       start;
   logic                       done;
   logic [BW-1:0]              beat;
   logic [LANES-1:0][XLEN-1:0] wr_lanes;
   logic [LANES-1:0][XLEN-1:0] rd_buf_q;
   logic [XLEN*LANES-1:0]      rd_data_d;

   assign access   = mem_mem_read | mem_mem_write;
   assign wr_lanes = mem_write_data;

   dmem_beat_ctrl #(.LANES(LANES), .BW(BW)) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .access_i    (access),
      .store_i     (mem_mem_write),
      .vector_i    (mem_vector_op),
      .base_addr_i (mem_alu_result[31:0]),
      .dmem_ack_i  (dmem_ack),
      .dmem_req_o  (dmem_req),
      .dmem_we_o   (dmem_we),
      .dmem_addr_o (dmem_addr),
      .beat_o      (beat),
      .done_o      (done),
      .stall_o     (mem_stall)
   );

   assign dmem_wdata = dmem_req ? wr_lanes[beat] : '0;

   // Access is still asserted during DONE (EX/MEM not yet advanced), so exclude it here.
   assign start = access & ~dmem_req & ~done;

   always_ff @(posedge clk) begin
      if (reset || start) begin
         rd_buf_q <= '0;
      end else if (dmem_req && dmem_ack && !dmem_we) begin
         rd_buf_q[beat] <= dmem_rdata;
      end
   end

   always_comb begin
      rd_data_d = '0;
      if (mem_vector_op) begin
         rd_data_d = rd_buf_q;
      end else begin
         rd_data_d[XLEN-1:0] = rd_buf_q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || wb_clear) begin
         wb_instr      <= '0;
         wb_reg_write  <= 1'b0;
         wb_result_src <= '0;
         wb_vector_op  <= 1'b0;
         wb_alu_result <= '0;
         wb_read_data  <= '0;
         wb_pc_plus_4  <= '0;
         wb_imm_ext    <= '0;
         wb_rd         <= '0;
      end else if (mem_stall) begin
         wb_reg_write <= 1'b0;
         wb_vector_op <= 1'b0;
         wb_rd        <= '0;
      end else begin
         wb_instr      <= mem_instr;
         wb_reg_write  <= mem_reg_write;
         wb_result_src <= mem_result_src;
         wb_vector_op  <= mem_vector_op;
         wb_alu_result <= mem_alu_result;
         wb_read_data  <= rd_data_d;
         wb_pc_plus_4  <= mem_pc_plus_4;
         wb_imm_ext    <= mem_imm_ext;
         wb_rd         <= mem_rd;
      end
   end
endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: acts as the data-memory slave with programmable wait states and
// checks bus beats, stall length and MEM/WB contents against a transaction-level model.
module tb_stage_memory;
   logic         clk = 1'b0;
   logic         reset, wb_clear;
   logic [31:0]  mem_instr;
   logic         mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op;
   logic [1:0]   mem_result_src;
   logic [127:0] mem_alu_result, mem_write_data, mem_imm_ext;
   logic [31:0]  mem_pc_plus_4;
   logic [4:0]   mem_rd;
   logic         dmem_req, dmem_we, dmem_ack, mem_stall;
   logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0]  wb_instr, wb_pc_plus_4;
   logic         wb_reg_write, wb_vector_op;
   logic [1:0]   wb_result_src;
   logic [127:0] wb_alu_result, wb_read_data, wb_imm_ext;
   logic [4:0]   wb_rd;

   always #5 clk = ~clk;

   stage_memory #(.XLEN(32), .LANES(4)) dut (
      .clk(clk), .reset(reset), .wb_clear(wb_clear), .mem_instr(mem_instr),
      .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
      .mem_mem_read(mem_mem_read), .mem_vector_op(mem_vector_op),
      .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
      .mem_write_data(mem_write_data), .mem_pc_plus_4(mem_pc_plus_4),
      .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .mem_stall(mem_stall), .wb_instr(wb_instr), .wb_reg_write(wb_reg_write),
      .wb_result_src(wb_result_src), .wb_vector_op(wb_vector_op),
      .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
      .wb_pc_plus_4(wb_pc_plus_4), .wb_imm_ext(wb_imm_ext), .wb_rd(wb_rd)
   );

   int total = 0;
   int bad   = 0;
   int wait_cfg[4];
   logic [31:0] mem_model [logic [31:0]];

   function automatic logic [31:0] mem_rd_word(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_inputs();
      mem_instr = '0; mem_reg_write = 0; mem_mem_write = 0; mem_mem_read = 0;
      mem_vector_op = 0; mem_result_src = '0; mem_alu_result = '0;
      mem_write_data = '0; mem_pc_plus_4 = '0; mem_imm_ext = '0; mem_rd = '0;
      dmem_ack = 0; dmem_rdata = '0;
   endtask

   task automatic test_reset();
      reset = 1; wb_clear = 0; idle_inputs();
      repeat (2) @(negedge clk);
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", dmem_req); end
      total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", dmem_we); end
      total++; if (dmem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", dmem_addr); end
      total++; if (dmem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", dmem_wdata); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
      total++; if ({wb_instr, wb_reg_write, wb_result_src, wb_vector_op, wb_alu_result, wb_read_data,
                    wb_pc_plus_4, wb_imm_ext, wb_rd} !== '0) begin
         bad++; $display("FAIL reset_wb: got nonzero MEM/WB (rd=%h alu=%h) want all 0", wb_rd, wb_alu_result);
      end
      reset = 0;
      @(negedge clk);
   endtask

   // One memory instruction from EX/MEM through DONE; called just after a negedge.
   task automatic do_access(input bit st, input bit vec, input logic [31:0] base,
                            input logic [127:0] wd, input bit rw, input string nm);
      int nb, beat, wleft, stalls, exp_stall, cyc;
      bit fin;
      logic [31:0]  ab, ea, instr, pc;
      logic [127:0] exp_rd, alu, imm;
      logic [4:0]   rd;
      logic [1:0]   rs;
      nb = vec ? 4 : 1;
      ab = {base[31:2], 2'b00};
      exp_rd = '0;
      exp_stall = 1 + nb;
      for (int i = 0; i < nb; i++) begin
         exp_stall += wait_cfg[i];
         if (!st) exp_rd[32*i +: 32] = mem_rd_word(ab + 32'(4*i));
      end
      instr = $urandom; pc = $urandom; imm = rnd128(); rd = 5'($urandom); rs = 2'($urandom);
      alu = {$urandom, $urandom, $urandom, base};
      mem_instr = instr; mem_reg_write = rw; mem_mem_write = st;
      mem_mem_read = st ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_vector_op = vec; mem_result_src = rs; mem_alu_result = alu;
      mem_write_data = wd; mem_pc_plus_4 = pc; mem_imm_ext = imm; mem_rd = rd;
      dmem_ack = 0;
      #1;
      beat = 0; wleft = wait_cfg[0]; stalls = 0; cyc = 0; fin = 0;
      while (!fin) begin
         if (mem_stall) begin
            stalls++;
            if (stalls >= 2) begin
               total++;
               if (wb_reg_write !== 1'b0 || wb_rd !== 5'd0) begin
                  bad++; $display("FAIL %s bubble: got we=%b rd=%0d want 0/0", nm, wb_reg_write, wb_rd);
               end
            end
            if (dmem_req) begin
               ea = ab + 32'(4*beat);
               total++;
               if (dmem_addr !== ea || dmem_we !== st || (st && dmem_wdata !== wd[32*beat +: 32])) begin
                  bad++;
                  $display("FAIL %s beat%0d: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                           nm, beat, dmem_addr, dmem_we, dmem_wdata, ea, st, wd[32*beat +: 32]);
               end
               if (wleft > 0) begin
                  dmem_ack = 0; wleft--;
               end else begin
                  dmem_ack = 1;
                  if (st) mem_model[dmem_addr] = dmem_wdata;
                  else dmem_rdata = mem_rd_word(dmem_addr);
                  beat++;
                  if (beat < nb) wleft = wait_cfg[beat];
               end
            end else begin
               dmem_ack = 0;
            end
         end else begin
            total++;
            if (dmem_req !== 1'b0) begin bad++; $display("FAIL %s done_req: got %b want 0", nm, dmem_req); end
            dmem_ack = 0;
            fin = 1;
         end
         @(negedge clk);
         cyc++;
         if (!fin && cyc > 60) begin
            bad++; total++;
            $display("FAIL %s timeout: got no end of stall after %0d cycles want %0d", nm, cyc, exp_stall);
            fin = 1;
         end
      end
      dmem_ack = 0;
      total++;
      if (stalls != exp_stall || beat != nb) begin
         bad++; $display("FAIL %s stall_len: got %0d stalls/%0d beats want %0d/%0d", nm, stalls, beat, exp_stall, nb);
      end
      total++;
      if (wb_read_data !== exp_rd) begin
         bad++; $display("FAIL %s rdata: got %h want %h", nm, wb_read_data, exp_rd);
      end
      total++;
      if (wb_reg_write !== rw || wb_rd !== rd || wb_vector_op !== vec || wb_instr !== instr ||
          wb_result_src !== rs || wb_alu_result !== alu || wb_pc_plus_4 !== pc || wb_imm_ext !== imm) begin
         bad++;
         $display("FAIL %s wb_fields: got we=%b rd=%0d vec=%b instr=%h want we=%b rd=%0d vec=%b instr=%h",
                  nm, wb_reg_write, wb_rd, wb_vector_op, wb_instr, rw, rd, vec, instr);
      end
   endtask

   task automatic do_alu(input logic [4:0] rd, input bit rw, input string nm);
      logic [31:0]  instr, pc;
      logic [127:0] alu, imm;
      logic [1:0]   rs;
      bit vec;
      instr = $urandom; pc = $urandom; alu = rnd128(); imm = rnd128(); rs = 2'($urandom);
      vec = 1'($urandom);
      mem_instr = instr; mem_reg_write = rw; mem_mem_write = 0; mem_mem_read = 0;
      mem_vector_op = vec; mem_result_src = rs; mem_alu_result = alu;
      mem_write_data = rnd128(); mem_pc_plus_4 = pc; mem_imm_ext = imm; mem_rd = rd;
      #1;
      total++;
      if (mem_stall !== 1'b0) begin bad++; $display("FAIL %s stall: got %b want 0", nm, mem_stall); end
      @(negedge clk);
      total++;
      if (wb_reg_write !== rw || wb_rd !== rd || wb_instr !== instr || wb_alu_result !== alu ||
          wb_vector_op !== vec || wb_result_src !== rs || wb_pc_plus_4 !== pc || wb_imm_ext !== imm) begin
         bad++;
         $display("FAIL %s wb_fields: got we=%b rd=%0d alu=%h want we=%b rd=%0d alu=%h",
                  nm, wb_reg_write, wb_rd, wb_alu_result, rw, rd, alu);
      end
   endtask

   task automatic test_scalar_load();
      wait_cfg = '{0, 0, 0, 0};
      mem_model[32'h100] = 32'hDEAD_BEEF;
      do_access(0, 0, 32'h100, rnd128(), 1, "scalar_load");
      total++;
      if (wb_read_data !== 128'hDEAD_BEEF) begin
         bad++; $display("FAIL scalar_load_value: got %h want DEADBEEF", wb_read_data);
      end
   endtask

   task automatic test_vector_store_load();
      wait_cfg = '{0, 0, 0, 0};
      do_access(1, 1, 32'h203, {32'h44, 32'h33, 32'h22, 32'h11}, 0, "vec_store");
      wait_cfg = '{0, 0, 2, 0};
      do_access(0, 1, 32'h200, rnd128(), 1, "vec_load_wait");
      total++;
      if (wb_read_data !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
         bad++; $display("FAIL vec_load_value: got %h want 44..33..22..11", wb_read_data);
      end
   endtask

   task automatic test_wrap();
      wait_cfg = '{0, 1, 0, 0};
      do_access(0, 1, 32'hFFFF_FFF8, rnd128(), 1, "vec_wrap");
   endtask

   task automatic test_back_to_back();
      wait_cfg = '{0, 0, 0, 0};
      do_access(1, 0, 32'h0000_0040, rnd128(), 0, "b2b_store");
      do_access(0, 0, 32'h0000_0042, rnd128(), 1, "b2b_load");
      do_access(0, 1, 32'h0000_0030, rnd128(), 1, "b2b_vload");
   endtask

   task automatic test_reset_mid();
      logic [31:0] ab;
      ab = 32'h0000_0500;
      do_alu(5'd3, 1, "pre_reset_alu");
      mem_mem_read = 1; mem_mem_write = 0; mem_vector_op = 1; mem_reg_write = 1;
      mem_alu_result = {96'h0, ab}; mem_rd = 5'd9; dmem_ack = 0;
      @(negedge clk);
      dmem_ack = 1; dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      dmem_ack = 0;
      total++;
      if (dmem_req !== 1'b1 || dmem_addr !== ab + 32'd4) begin
         bad++; $display("FAIL rst_mid_beat1: got req=%b addr=%h want 1/%h", dmem_req, dmem_addr, ab + 32'd4);
      end
      reset = 1;
      @(negedge clk);
      total++;
      if (dmem_req !== 1'b0 || dmem_addr !== 32'h0) begin
         bad++; $display("FAIL rst_mid_req: got req=%b addr=%h want 0/0", dmem_req, dmem_addr);
      end
      total++;
      if (wb_reg_write !== 1'b0 || wb_rd !== 5'd0 || wb_read_data !== '0) begin
         bad++; $display("FAIL rst_mid_wb: got we=%b rd=%0d want 0/0", wb_reg_write, wb_rd);
      end
      reset = 0; idle_inputs();
      @(negedge clk);
      total++;
      if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
         bad++; $display("FAIL rst_mid_idle: got req=%b stall=%b want 0/0", dmem_req, mem_stall);
      end
   endtask

   task automatic test_alu_clear();
      do_alu(5'd7, 1, "alu_rd7");
      idle_inputs();
      wb_clear = 1;
      @(negedge clk);
      wb_clear = 0;
      total++;
      if ({wb_instr, wb_reg_write, wb_result_src, wb_vector_op, wb_alu_result, wb_read_data,
           wb_pc_plus_4, wb_imm_ext, wb_rd} !== '0) begin
         bad++; $display("FAIL wb_clear: got rd=%0d alu=%h want all 0", wb_rd, wb_alu_result);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            do_alu(5'($urandom), 1'($urandom), "rnd_alu");
         end else begin
            for (int i = 0; i < 4; i++) wait_cfg[i] = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : (32'($urandom) & 32'h0000_0FFF);
            do_access(1'($urandom), 1'($urandom), a, rnd128(), 1'($urandom), "rnd_access");
         end
      end
      idle_inputs();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_scalar_load();
      test_vector_store_load();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_alu_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stage_memory.md
# stage_memory

Memory pipeline stage of the core, the consumer of the execute stage's EX/MEM register outputs. It performs scalar (32-bit) and vector (128-bit, four-lane) loads and stores over a 32-bit single-port data-memory bus with a req/ack handshake. Vector accesses are sequenced as four word beats. The stage stalls the front of the pipeline while a transaction is in flight and registers results into the MEM/WB pipeline register.

## Interface
Parameters:
- XLEN, 32: scalar word and bus data width.
- LANES, 4: words per vector; vector width = XLEN*LANES (128).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- wb_clear  in  1  synchronous flush of the MEM/WB register (from hazard unit).
- mem_instr  in  32  debug instruction word.
- mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op  in  1 each  control from EX/MEM.
- mem_result_src  in  2  writeback mux select, passed through.
- mem_alu_result  in  128  address in [31:0]; ALU result passed through.
- mem_write_data  in  128  store data; lane i = bits [32i+31:32i].
- mem_pc_plus_4  in  32;  mem_imm_ext  in  128;  mem_rd  in  5  passed through.
- dmem_req  out  1  bus request; dmem_we  out  1  write enable.
- dmem_addr  out  32  word address, bits [1:0] always 0.
- dmem_wdata  out  32;  dmem_rdata  in  32;  dmem_ack  in  1  beat complete, rdata valid in the same cycle.
- mem_stall  out  1  to hazard unit; holds the PC and the IF/ID, ID/EX and EX/MEM registers.
- wb_instr 32, wb_reg_write 1, wb_result_src 2, wb_vector_op 1, wb_alu_result 128, wb_read_data 128, wb_pc_plus_4 32, wb_imm_ext 128, wb_rd 5  out  MEM/WB register.

## Operation
- access = mem_mem_read | mem_mem_write. When both are set, the access is a store.
- last_beat = LANES-1 if mem_vector_op, else 0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if access, go to ACCESS with beat=0. Otherwise stay in IDLE.
  - ACCESS: dmem_req=1, dmem_we=store, dmem_addr = {base[31:2],2'b00} + 4*beat (wraps mod 2^32), dmem_wdata = mem_write_data lane beat.
    - On dmem_ack for a load, capture dmem_rdata into rd_buf lane beat.
    - On dmem_ack with beat==last_beat, go to DONE. Otherwise beat+1.
    - Without ack, hold every bus output stable.
  - DONE: one cycle, then IDLE.
- mem_stall = (IDLE & access) | ACCESS. It is combinational and 0 in DONE.
- MEM/WB register update, every cycle, first match wins:
  - reset or wb_clear: all wb_* = 0.
  - mem_stall: insert a bubble. wb_reg_write=0, wb_vector_op=0, wb_rd=0. Other wb_* hold.
  - otherwise: capture all pass-through fields. wb_read_data = rd_buf; for a scalar load, lanes 1..3 = 0.
- rd_buf is cleared on entry to ACCESS.
- Non-memory instructions never stall and flow through in one cycle.
- A started bus transaction cannot be aborted except by reset. EX/MEM is held by mem_stall, so its inputs are stable in ACCESS.

## Timing
- Reset values: state=IDLE, beat=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, mem_stall=0 (with no access on input), all wb_*=0.
- Reset mid-ACCESS: dmem_req drops in the next cycle. Nothing is written to WB.
- Latency with zero-wait ack: scalar access = 3 cycles (IDLE stall, ACCESS, DONE), so 2 stall cycles. Vector access = 6 cycles, 5 stall cycles.
- Each wait cycle without ack adds one cycle.
- Back-to-back accesses: the next access enters IDLE the cycle after DONE and stalls immediately.
- The WB result appears on the clock edge that ends DONE.

## Structure
- core_pkg holds:
  - typedef enum logic [1:0] mem_state_t {IDLE, ACCESS, DONE}
  - localparam WORD_W=32, VLANES=4
- Sub-module dmem_beat_ctrl contains the FSM, beat counter, address generation and handshake. It outputs beat, done and stall.
- stage_memory contains the rd_buf lanes, the store-lane mux and the MEM/WB register.

## Test plan
- Scalar load, addr 0x100, ack in the same cycle, rdata=0xDEADBEEF → mem_stall high 2 cycles; wb_read_data=0x...0000_DEADBEEF; wb_reg_write=1 after DONE.
- Vector store, addr 0x203, data lanes {0x44,0x33,0x22,0x11} → beats at addr 0x200/204/208/20C with wdata 0x11/22/33/44 (lane 0 first), dmem_we=1, 5 stall cycles.
- Vector load, 2 wait cycles on beat 2 → addr/req held stable; total stall 7 cycles; lanes assembled in order.
- Vector load at 0xFFFFFFF8 → beats at FFFFFFF8, FFFFFFFC, 00000000, 00000004 (wrap).
- Reset asserted in ACCESS beat 1 → next cycle dmem_req=0, state IDLE, wb_reg_write=0.
- ALU op with mem_reg_write=1, rd=7, then wb_clear → WB captures rd=7 in 1 cycle with no stall; wb_clear zeroes all wb_*.
